sensor_seq_gen: RTL and testbench

Stimulus generator for the two-beam parking-gate sensor interface (beams A and B). On command it drives the A/B pair through the exact phase sequence a car produces when entering or leaving, or a deliberately invalid pattern, holding each phase for a programmable number of clock cycles. It is the transmitting end of the A/B interface whose receiver is the entry/exit detector FSM, and is used on-board to exercise that detector without physical sensors.

---
 rtl/sensor_seq_gen.sv | 158 +++++++++++++++
 tb/tb_sensor_seq_gen.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/sensor_seq_gen.sv
// ---------------------------------------------------------------------------
// sensor_seq_gen
// Stimulus generator for a two-beam (A/B) parking-gate sensor interface.
// On an accepted command it plays back the beam sequence of a car entering,
// a car leaving, a deliberately invalid glitch, or a quiet gap. Each phase
// is held for a programmable number of cycles and always ends with A=B=0.
//
// Ports
//   clk        system clock, rising edge
//   rst        synchronous reset, active-high
//   req_valid  command request
//   req_cmd    0 = entry, 1 = exit, 2 = glitch, 3 = quiet gap
//   dwell      cycles per phase (0 behaves as 1), sampled on acceptance
//   req_ready  idle and able to accept a command
//   A, B       registered beam outputs (1 = beam blocked)
//   busy       sequence in progress, always ~req_ready
//   done       one-cycle pulse in the first idle cycle after a sequence
//   done_cmd   command that just completed, valid while done = 1
// ---------------------------------------------------------------------------
module sensor_seq_gen #(
   parameter int DWELL_W = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               req_valid,
   input  logic [1:0]         req_cmd,
   input  logic [DWELL_W-1:0] dwell,
   output logic               req_ready,
   output logic               A,
   output logic               B,
   output logic               busy,
   output logic               done,
   output logic [1:0]         done_cmd
);

   typedef enum logic {S_IDLE, S_RUN} state_t;

   state_t             r_state, w_state_nxt;
   logic [1:0]         r_phase, w_phase_nxt;
   logic [DWELL_W-1:0] r_cnt,   w_cnt_nxt;
   logic [DWELL_W-1:0] r_dm1,   w_dm1_nxt;
   logic [1:0]         r_cmd,   w_cmd_nxt;
   logic [1:0]         r_ab,    w_ab_nxt;
   logic               r_done,  w_done_nxt;
   logic [DWELL_W-1:0] w_dwell_m1;

   // {A,B} value driven in a given phase of a given command.
   function automatic logic [1:0] f_phase_ab(input logic [1:0] cmd,
                                             input logic [1:0] ph);
      logic [1:0] ab;
      ab = 2'b00;
      case (cmd)
         2'd0: case (ph)
                  2'd0:    ab = 2'b10;
                  2'd1:    ab = 2'b11;
                  2'd2:    ab = 2'b01;
                  default: ab = 2'b00;
               endcase
         2'd1: case (ph)
                  2'd0:    ab = 2'b01;
                  2'd1:    ab = 2'b11;
                  2'd2:    ab = 2'b10;
                  default: ab = 2'b00;
               endcase
         2'd2:    ab = (ph == 2'd0) ? 2'b11 : 2'b00;
         default: ab = 2'b00;
      endcase
      return ab;
   endfunction

   // Index of the final (always 00) phase of each command.
   function automatic logic [1:0] f_last_phase(input logic [1:0] cmd);
      logic [1:0] lp;
      case (cmd)
         2'd0, 2'd1: lp = 2'd3;
         2'd2:       lp = 2'd1;
         default:    lp = 2'd0;
      endcase
      return lp;
   endfunction

   // A zero dwell is treated as a one-cycle dwell, so the reload value is D-1.
   assign w_dwell_m1 = (dwell == '0) ? '0 : (dwell - DWELL_W'(1));

   always_comb begin
      w_state_nxt = r_state;
      w_phase_nxt = r_phase;
      w_cnt_nxt   = r_cnt;
      w_dm1_nxt   = r_dm1;
      w_cmd_nxt   = r_cmd;
      w_ab_nxt    = r_ab;
      w_done_nxt  = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_ab_nxt = 2'b00;
            if (req_valid) begin
               w_state_nxt = S_RUN;
               w_cmd_nxt   = req_cmd;
               w_dm1_nxt   = w_dwell_m1;
               w_cnt_nxt   = w_dwell_m1;
               w_phase_nxt = 2'd0;
               w_ab_nxt    = f_phase_ab(req_cmd, 2'd0);
            end
         end
         S_RUN: begin
            if (r_cnt != '0) begin
               w_cnt_nxt = r_cnt - DWELL_W'(1);
            end else if (r_phase == f_last_phase(r_cmd)) begin
               // Last cycle of the trailing 00 phase: done shows in the
               // first idle cycle, which is also able to accept.
               w_state_nxt = S_IDLE;
               w_phase_nxt = 2'd0;
               w_ab_nxt    = 2'b00;
               w_done_nxt  = 1'b1;
            end else begin
               w_phase_nxt = r_phase + 2'd1;
               w_cnt_nxt   = r_dm1;
               w_ab_nxt    = f_phase_ab(r_cmd, r_phase + 2'd1);
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_ab_nxt    = 2'b00;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_phase <= 2'd0;
         r_cnt   <= '0;
         r_cmd   <= 2'd0;
         r_ab    <= 2'b00;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_phase <= w_phase_nxt;
         r_cnt   <= w_cnt_nxt;
         r_cmd   <= w_cmd_nxt;
         r_ab    <= w_ab_nxt;
         r_done  <= w_done_nxt;
      end
   end

   // Reload value is pure data; it is only read after being loaded.
   always_ff @(posedge clk) begin
      r_dm1 <= w_dm1_nxt;
   end

   assign req_ready = (r_state == S_IDLE);
   assign busy      = ~req_ready;
   assign A         = r_ab[1];
   assign B         = r_ab[0];
   assign done      = r_done;
   assign done_cmd  = r_cmd;

endmodule

// File: tb/tb_sensor_seq_gen.sv
// ---------------------------------------------------------------------------
// tb_sensor_seq_gen
// Scoreboard bench for sensor_seq_gen. The stimulus side keeps a simple
// cycle-budget model of the generator (ready / done timing) and pushes the
// full expected beam trace of each accepted command into a queue. A monitor
// samples on the falling edge, collects the beam trace while busy and pops
// and compares it when done pulses.
// ---------------------------------------------------------------------------
module tb_sensor_seq_gen;

   localparam int DW = 16;

   logic          clk;
   logic          rst;
   logic          req_valid;
   logic [1:0]    req_cmd;
   logic [DW-1:0] dwell;
   logic          req_ready;
   logic          A;
   logic          B;
   logic          busy;
   logic          done;
   logic [1:0]    done_cmd;

   sensor_seq_gen #(.DWELL_W(DW)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_cmd   (req_cmd),
      .dwell     (dwell),
      .req_ready (req_ready),
      .A         (A),
      .B         (B),
      .busy      (busy),
      .done      (done),
      .done_cmd  (done_cmd)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]   cmd;
      logic [255:0] tr;
      int           len;
   } exp_t;

   exp_t q[$];

   int   nchk = 0;
   int   nerr = 0;
   bit   mon_en = 1'b0;
   bit   ready_m = 1'b1;
   bit   exp_done = 1'b0;
   int   m_rem = 0;
   bit   last_acc = 1'b0;

   task automatic chk(input string nm, input logic [255:0] act,
                      input logic [255:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Expected beam trace straight from the phase lists: each {A,B} entry
   // repeated D times.
   function automatic exp_t build_exp(input logic [1:0] cmd,
                                      input logic [DW-1:0] d);
      exp_t e;
      logic [7:0] pk;
      int n;
      int deff;
      case (cmd)
         2'd0:    begin pk = 8'b10_11_01_00; n = 4; end
         2'd1:    begin pk = 8'b01_11_10_00; n = 4; end
         2'd2:    begin pk = 8'b11_00_00_00; n = 2; end
         default: begin pk = 8'b00_00_00_00; n = 1; end
      endcase
      deff = (d == 0) ? 1 : int'(d);
      e.cmd = cmd;
      e.tr  = '0;
      e.len = 0;
      for (int p = 0; p < n; p++) begin
         for (int k = 0; k < deff; k++) begin
            e.tr = (e.tr << 2) | {254'd0, pk[7-2*p -: 2]};
            e.len++;
         end
      end
      return e;
   endfunction

   // One clock of stimulus plus the timing model update.
   task automatic step(input logic v, input logic [1:0] c,
                       input logic [DW-1:0] d, input logic r);
      bit acc;
      exp_t e;
      req_valid = v;
      req_cmd   = c;
      dwell     = d;
      rst       = r;
      acc       = v && ready_m && !r;
      @(posedge clk);
      if (r) begin
         q.delete();
         m_rem    = 0;
         exp_done = 1'b0;
      end else begin
         exp_done = (m_rem == 1);
         if (acc) begin
            e = build_exp(c, d);
            q.push_back(e);
            m_rem = e.len;
         end else if (m_rem > 0) begin
            m_rem--;
         end
      end
      ready_m  = (m_rem == 0);
      last_acc = acc;
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 2'd0, '0, 1'b0);
   endtask

   task automatic send(input logic [1:0] c, input logic [DW-1:0] d);
      int tries;
      tries = 0;
      do begin
         step(1'b1, c, d, 1'b0);
         tries++;
      end while (!last_acc && tries < 2000);
      if (!last_acc) chk("accept_timeout", 1, 0);
   endtask

   // Monitor: samples away from the active edge.
   logic [255:0] tr;
   int           tr_len;
   exp_t         got;

   initial begin
      tr = '0;
      tr_len = 0;
      forever begin
         @(negedge clk);
         if (mon_en) begin
            chk("req_ready", {255'd0, req_ready}, {255'd0, ready_m});
            chk("busy_vs_ready", {255'd0, busy}, {255'd0, ~req_ready});
            chk("done_timing", {255'd0, done}, {255'd0, exp_done});
            if (busy) begin
               tr = (tr << 2) | {254'd0, A, B};
               tr_len++;
            end else begin
               chk("idle_ab", {254'd0, A, B}, 256'd0);
            end
            if (done) begin
               if (q.size() == 0) begin
                  chk("done_unexpected", 1, 0);
               end else begin
                  got = q.pop_front();
                  chk("done_cmd", {254'd0, done_cmd}, {254'd0, got.cmd});
                  chk("trace_len", tr_len, got.len);
                  chk("trace", tr, got.tr);
               end
            end
            if (!busy) begin
               tr = '0;
               tr_len = 0;
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int r;
      int waitn;
      rst       = 1'b1;
      req_valid = 1'b0;
      req_cmd   = 2'd0;
      dwell     = '0;
      repeat (3) @(posedge clk);
      #1;
      ready_m = 1'b1;
      m_rem   = 0;
      mon_en  = 1'b1;
      idle(2);

      // Directed cases from the feature list.
      send(2'd0, 16'd2);
      idle(12);
      send(2'd1, 16'd0);
      idle(8);
      send(2'd2, 16'd3);
      send(2'd3, 16'd3);
      idle(10);
      send(2'd0, 16'd4);
      send(2'd1, 16'd7);
      idle(40);
      send(2'd0, 16'd5);
      idle(7);
      step(1'b1, 2'd1, 16'd2, 1'b1);
      idle(40);
      send(2'd0, 16'd10);
      send(2'd1, 16'd10);
      send(2'd2, 16'd10);
      idle(5);

      // Randomized traffic, including occasional resets.
      for (int i = 0; i < 400; i++) begin
         r = $urandom_range(0, 99);
         if (r < 2)
            step(1'b1, 2'($urandom_range(0, 3)), DW'($urandom_range(0, 5)), 1'b1);
         else
            step(r < 55, 2'($urandom_range(0, 3)), DW'($urandom_range(0, 5)), 1'b0);
      end

      waitn = 0;
      while (m_rem != 0 && waitn < 1000) begin
         idle(1);
         waitn++;
      end
      if (m_rem != 0) chk("drain_timeout", 1, 0);
      idle(3);
      chk("queue_empty", q.size(), 0);
      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
